// File: rtl/maxpool_stage.sv
// maxpool_stage
//   2x2, stride-2 max-pool of the 64x64 layer-0 map into the 32x32 layer-1
//   map. Each output k (0..1023, raster order) is produced in six cycles:
//   four reads, one cycle to fold in the last read word, and one write.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle request, accepted only in IDLE
//   busy       high from the cycle after an accepted start through FIN
//   done       one-cycle pulse in FIN, after the final write
//   crd        layer-memory read strobe (R0..R3)
//   caddr_rd   layer-memory read address
//   cdata_rd   layer-memory read data, valid the cycle after crd/caddr_rd
//   cwr        layer-memory write strobe (WR only)
//   caddr_wr   layer-memory write address (= k)
//   cdata_wr   layer-memory write data (pooled, optionally rounded up)
//   csel       3'b001 layer-0 map, 3'b011 layer-1 map, 3'b000 idle
//   state_dbg  current FSM state, for observation only
//
// Handshake: start is a request pulse with no ready. It is taken only when
// the FSM sits in IDLE; anywhere else, FIN included, it is dropped. busy
// covers the whole pass and done marks its end.
//
// All outputs are registered: every transition assigns the outputs that
// belong to the state being entered, so each output is a pure function of
// the state it is observed in.

module maxpool_stage #(
  parameter int ROUND_UP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0   = 3'd1,
    R1   = 3'd2,
    R2   = 3'd3,
    R3   = 3'd4,
    MX   = 3'd5,
    WR   = 3'd6,
    FIN  = 3'd7
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0   = 3'b001;
  localparam logic [2:0] SEL_L1   = 3'b011;

  state_t      state;
  logic [9:0]  k;
  logic [19:0] max_q;
  logic [19:0] rd_max;
  logic [9:0]  k_inc;

  assign state_dbg = state;
  assign k_inc     = k + 10'd1;

  // Strict compare so that on a tie the earlier word is kept.
  assign rd_max = (cdata_rd > max_q) ? cdata_rd : max_q;

  // Top-left corner of the 2x2 window: oy*128 + ox*2. Bits 0 and 6 are
  // always zero, so the +1/+64/+65 offsets never carry.
  function automatic logic [11:0] base_addr(input logic [9:0] kk);
    return {kk[9:5], 1'b0, kk[4:0], 1'b0};
  endfunction

  // Data is 4.16 fixed point. A non-zero fraction rounds up to the next
  // integer, except that integer part 15 has no next integer and saturates
  // to 15.0.
  function automatic logic [19:0] round_val(input logic [19:0] m);
    if (ROUND_UP == 0 || m[15:0] == 16'h0) begin
      return m;
    end else if (m[19:16] == 4'hF) begin
      return 20'hF_0000;
    end else begin
      return {m[19:16] + 4'd1, 16'h0};
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= 10'd0;
      max_q    <= 20'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= 12'd0;
      caddr_wr <= 12'd0;
      cdata_wr <= 20'd0;
      csel     <= SEL_NONE;
    end else begin
      // Strobes are single-state; each transition re-raises what it needs.
      crd  <= 1'b0;
      cwr  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= R0;
            busy     <= 1'b1;
            crd      <= 1'b1;
            caddr_rd <= base_addr(k);
            csel     <= SEL_L0;
          end
        end
        R0: begin
          state    <= R1;
          crd      <= 1'b1;
          caddr_rd <= base_addr(k) + 12'd1;
        end
        R1: begin
          // d0 arrives now; it seeds the running maximum.
          state    <= R2;
          crd      <= 1'b1;
          caddr_rd <= base_addr(k) + 12'd64;
          max_q    <= cdata_rd;
        end
        R2: begin
          state    <= R3;
          crd      <= 1'b1;
          caddr_rd <= base_addr(k) + 12'd65;
          max_q    <= rd_max;
        end
        R3: begin
          state <= MX;
          max_q <= rd_max;
        end
        MX: begin
          // d3 arrives now; fold it in and present the result for WR.
          state    <= WR;
          max_q    <= rd_max;
          cwr      <= 1'b1;
          caddr_wr <= {2'b00, k};
          cdata_wr <= round_val(rd_max);
          csel     <= SEL_L1;
        end
        WR: begin
          // k_inc wraps 1023 -> 0, which leaves k ready for the next pass.
          k <= k_inc;
          if (k == 10'd1023) begin
            state <= FIN;
            done  <= 1'b1;
            csel  <= SEL_NONE;
          end else begin
            state    <= R0;
            crd      <= 1'b1;
            caddr_rd <= base_addr(k_inc);
            csel     <= SEL_L0;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          csel  <= SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_stage.sv
// tb_maxpool_stage
//   Bench for maxpool_stage. Two instances run in lockstep from the same
//   memory image: dut with rounding enabled, dut0 with the raw maximum.
//   Expected read addresses and writes come from a plain arithmetic model of
//   the pooling operation computed over the memory image.

module tb_maxpool_stage;

  logic        clk;
  logic        reset;
  logic        start;

  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr;
  logic [2:0]  csel, state_dbg;

  logic        busy0, done0, crd0, cwr0;
  logic [11:0] caddr_rd0, caddr_wr0;
  logic [19:0] cdata_rd0, cdata_wr0;
  logic [2:0]  csel0, state_dbg0;

  logic [19:0] mem [4096];

  logic [31:0] exp_q[$];   // {addr, data} for the rounding instance
  logic [31:0] exp0_q[$];  // {addr, data} for the raw instance
  logic [11:0] rd_exp_q[$];

  int n_cmp;
  int n_err;
  int wr_cnt;
  int wr0_cnt;
  int done_cnt;

  maxpool_stage #(.ROUND_UP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
    .state_dbg(state_dbg)
  );

  maxpool_stage #(.ROUND_UP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .crd(crd0), .caddr_rd(caddr_rd0), .cdata_rd(cdata_rd0), .cwr(cwr0),
    .caddr_wr(caddr_wr0), .cdata_wr(cdata_wr0), .csel(csel0),
    .state_dbg(state_dbg0)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Layer memory: address and strobe in cycle t, data in cycle t+1.
  initial begin
    cdata_rd  = 20'd0;
    cdata_rd0 = 20'd0;
  end
  always @(posedge clk) begin
    if (crd)  cdata_rd  <= mem[caddr_rd];
    if (crd0) cdata_rd0 <= mem[caddr_rd0];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [19:0] ref_round(input logic [19:0] m);
    int ip, frac;
    ip   = int'(m) / 65536;
    frac = int'(m) % 65536;
    if (frac == 0) return m;
    if (ip == 15) return 20'hF_0000;
    return 20'((ip + 1) * 65536);
  endfunction

  task automatic build_expected();
    int oy, ox, base;
    int a [4];
    logic [19:0] m;
    exp_q.delete();
    exp0_q.delete();
    rd_exp_q.delete();
    for (int kk = 0; kk < 1024; kk++) begin
      oy = kk / 32;
      ox = kk % 32;
      base = oy * 128 + ox * 2;
      a[0] = base; a[1] = base + 1; a[2] = base + 64; a[3] = base + 65;
      m = 20'd0;
      for (int j = 0; j < 4; j++) begin
        rd_exp_q.push_back(12'(a[j]));
        if (mem[a[j]] > m) m = mem[a[j]];
      end
      exp_q.push_back({12'(kk), ref_round(m)});
      exp0_q.push_back({12'(kk), m});
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) check("crd_cwr_excl", {31'd0, crd & cwr}, 32'd0);
    if (crd) begin
      if (rd_exp_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
      else check("rd_addr", {20'd0, caddr_rd}, {20'd0, rd_exp_q.pop_front()});
      check("csel_rd", {29'd0, csel}, 32'd1);
    end
    if (cwr) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", {20'd0, caddr_wr}, {20'd0, e[31:20]});
        check("wr_data", {12'd0, cdata_wr}, {12'd0, e[19:0]});
      end
      check("csel_wr", {29'd0, csel}, 32'd3);
    end
    if (cwr0) begin
      wr0_cnt++;
      if (exp0_q.size() == 0) check("wr0_extra", 32'd1, 32'd0);
      else begin
        e = exp0_q.pop_front();
        check("wr0_addr", {20'd0, caddr_wr0}, {20'd0, e[31:20]});
        check("wr0_data", {12'd0, cdata_wr0}, {12'd0, e[19:0]});
      end
    end
    if (done) done_cnt++;
  end

  // ---------------- drivers ----------------
  // mode 0: {4'h0, n, 4'h0}; mode 1: random; mode 2: all zero
  task automatic fill_mem(input int mode);
    for (int n = 0; n < 4096; n++) begin
      case (mode)
        0: mem[n] = {4'h0, 12'(n), 4'h0};
        1: begin
          mem[n] = 20'($urandom_range(0, 20'hF_FFFF));
          if ($urandom_range(0, 3) == 0) mem[n][15:0] = 16'h0;
          if (n > 0 && $urandom_range(0, 7) == 0) mem[n] = mem[n - 1];
        end
        default: mem[n] = 20'd0;
      endcase
    end
    if (mode == 1) begin
      // k = 0 window
      mem[0]  = 20'h1_0000; mem[1]  = 20'h2_8000;
      mem[64] = 20'h0_FFFF; mem[65] = 20'h2_8000;
      // k = 1023 window: 4030, 4031, 4094, 4095
      mem[4030] = 20'h1_2345; mem[4031] = 20'h0_0000;
      mem[4094] = 20'hF_0001; mem[4095] = 20'hE_FFFF;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_crd"},   {31'd0, crd},  32'd0);
    check({tag, "_cwr"},   {31'd0, cwr},  32'd0);
    check({tag, "_raddr"}, {20'd0, caddr_rd}, 32'd0);
    check({tag, "_waddr"}, {20'd0, caddr_wr}, 32'd0);
    check({tag, "_wdata"}, {12'd0, cdata_wr}, 32'd0);
    check({tag, "_csel"},  {29'd0, csel}, 32'd0);
  endtask

  // One full pass. extra_start: cycle at which a stray start is pulsed
  // (0 = none). fin_start: also pulse start during the FIN cycle.
  task automatic run_pass(input int extra_start, input bit fin_start);
    int cnt;
    build_expected();
    wr_cnt = 0; wr0_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (cnt < 7000) begin
      @(negedge clk);
      cnt++;
      if (extra_start != 0 && cnt == extra_start) start = 1'b1;
      else start = 1'b0;
      if (done) break;
    end
    check("done_latency", cnt, 32'd6145);
    start = fin_start;
    @(negedge clk);
    start = 1'b0;
    check("busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("idle_after_fin", {31'd0, busy}, 32'd0);
    check("wr_count", wr_cnt, 32'd1024);
    check("wr0_count", wr0_cnt, 32'd1024);
    check("done_count", done_cnt, 32'd1);
    check("exp_left", exp_q.size(), 32'd0);
    check("rd_left", rd_exp_q.size(), 32'd0);
  endtask

  // Abort a pass with reset during the WR of k = 500.
  task automatic run_reset_abort();
    int cyc;
    bit hit;
    build_expected();
    wr_cnt = 0; wr0_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cwr && caddr_wr == 12'd500) begin
        hit = 1'b1;
        break;
      end
    end
    check("wr500_seen", {31'd0, hit}, 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    check("abort_wr_count", wr_cnt, 32'd500);
    check("abort_exp_left", exp_q.size(), 32'd524);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); exp0_q.delete(); rd_exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_abort_idle", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    wr_cnt = 0; wr0_cnt = 0; done_cnt = 0;
    start = 1'b0;
    reset = 1'b0;
    fill_mem(2);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    fill_mem(0);
    run_pass(100, 1'b0);

    fill_mem(1);
    run_pass(0, 1'b0);

    fill_mem(2);
    run_pass(0, 1'b1);

    fill_mem(1);
    run_reset_abort();
    run_pass(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
